// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared types and helpers for the feeder and the PE array
package kalman_pkg;

  localparam int DWIDTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } feeder_state_t;

  // Bit offset of lane `lane` inside a packed vector of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/feeder_buffer.sv
// rtl/feeder_buffer.sv - K x N operand store, whole-vector write, per-lane slot read
module feeder_buffer
  import kalman_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEFAULT,
  parameter int N      = 4,
  parameter int K      = 4
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0]   waddr,
  input  logic [N*DWIDTH-1:0]          wdata,
  input  logic [N*((K > 1) ? $clog2(K) : 1)-1:0] raddr,
  output logic [N*DWIDTH-1:0]          rdata
);

  localparam int AW = (K > 1) ? $clog2(K) : 1;

  logic [N*DWIDTH-1:0] mem [K];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Lane i only ever reads its own column of the selected slot.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      rdata[lane_lsb(i, DWIDTH) +: DWIDTH] =
        mem[raddr[i*AW +: AW]][lane_lsb(i, DWIDTH) +: DWIDTH];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads A/B operand matrices and feeds them skewed into an N x N array
module systolic_feeder
  import kalman_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEFAULT,
  parameter int N       = 4,
  parameter int K       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [N*DWIDTH-1:0] ld_data,
  input  logic                start,
  output logic [N*DWIDTH-1:0] a_out,
  output logic [N*DWIDTH-1:0] b_out,
  output logic [N-1:0]        a_en,
  output logic [N-1:0]        b_en,
  input  logic                pe_done,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int AW  = (K > 1) ? $clog2(K) : 1;
  localparam int CW  = $clog2(2*K + 1);
  localparam int TW  = $clog2(K + N);
  localparam int DCW = $clog2(TIMEOUT + 1);

  feeder_state_t       state;
  logic [CW-1:0]       beat_cnt;
  logic [TW-1:0]       t_cnt;
  logic [DCW-1:0]      drain_cnt;
  logic                accept;
  logic                a_we;
  logic                b_we;
  logic [AW-1:0]       a_waddr;
  logic [AW-1:0]       b_waddr;
  logic [N*AW-1:0]     raddr;
  logic [N-1:0]        lane_live;
  logic [N*DWIDTH-1:0] a_rd;
  logic [N*DWIDTH-1:0] b_rd;

  assign accept  = ld_valid & ld_ready;
  assign a_we    = accept && (beat_cnt < CW'(K));
  assign b_we    = accept && (beat_cnt >= CW'(K));
  assign a_waddr = AW'(beat_cnt);
  assign b_waddr = AW'(beat_cnt - CW'(K));

  feeder_buffer #(.DWIDTH(DWIDTH), .N(N), .K(K)) u_a_buf (
    .clk(clk), .we(a_we), .waddr(a_waddr), .wdata(ld_data), .raddr(raddr), .rdata(a_rd)
  );

  feeder_buffer #(.DWIDTH(DWIDTH), .N(N), .K(K)) u_b_buf (
    .clk(clk), .we(b_we), .waddr(b_waddr), .wdata(ld_data), .raddr(raddr), .rdata(b_rd)
  );

  // Lane i lags lane 0 by i cycles: at step t it carries vector t-i.
  always_comb begin
    raddr     = '0;
    lane_live = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(t_cnt) >= i && int'(t_cnt) < i + K) begin
        lane_live[i]       = 1'b1;
        raddr[i*AW +: AW]  = AW'(int'(t_cnt) - i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      t_cnt       <= '0;
      drain_cnt   <= '0;
      ld_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      a_out       <= '0;
      b_out       <= '0;
      a_en        <= '0;
      b_en        <= '0;
    end else begin
      done  <= 1'b0;
      a_en  <= '0;
      b_en  <= '0;
      a_out <= '0;
      b_out <= '0;
      if (accept) beat_cnt <= beat_cnt + CW'(1);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept && beat_cnt == CW'(2*K - 1)) begin
            state    <= ST_ARMED;
            ld_ready <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (start) begin
            state       <= ST_FEED;
            t_cnt       <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_FEED: begin
          for (int i = 0; i < N; i++) begin
            if (lane_live[i]) begin
              a_en[i] <= 1'b1;
              b_en[i] <= 1'b1;
              a_out[lane_lsb(i, DWIDTH) +: DWIDTH] <= a_rd[lane_lsb(i, DWIDTH) +: DWIDTH];
              b_out[lane_lsb(i, DWIDTH) +: DWIDTH] <= b_rd[lane_lsb(i, DWIDTH) +: DWIDTH];
            end
          end
          if (t_cnt == TW'(K + N - 2)) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            t_cnt <= t_cnt + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (pe_done) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (drain_cnt == DCW'(TIMEOUT - 1)) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          ld_ready  <= 1'b1;
          beat_cnt  <= '0;
          t_cnt     <= '0;
          drain_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder (N=K=4, double operands)
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 64;
  localparam int TO = 64;

  typedef struct {
    logic [N-1:0]    en;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [N*DW-1:0] ld_data = '0;
  logic            start = 1'b0;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic [N-1:0]    a_en;
  logic [N-1:0]    b_en;
  logic            pe_done = 1'b0;
  logic            busy;
  logic            done;
  logic            timeout_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  systolic_feeder #(.DWIDTH(DW), .N(N), .K(K), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .start(start), .a_out(a_out), .b_out(b_out), .a_en(a_en), .b_en(b_en),
    .pe_done(pe_done), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] make_vec(input int base);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $realtobits(real'(base + i));
    return v;
  endfunction

  // Element [k][i] of a matrix loaded from `base` is base + 4k + i.
  task automatic push_feed(input int ba, input int bb, input int steps);
    exp_t e;
    for (int t = 0; t < steps; t++) begin
      e.en = '0; e.a = '0; e.b = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < K) begin
          e.en[i]         = 1'b1;
          e.a[i*DW +: DW] = $realtobits(real'(ba + 4*(t - i) + i));
          e.b[i*DW +: DW] = $realtobits(real'(bb + 4*(t - i) + i));
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic load(input int ba, input int bb, input int nbeats, input int start_beat,
                      output int acc);
    acc = 0;
    for (int j = 0; j < nbeats; j++) begin
      ld_valid = 1'b1;
      start    = (j == start_beat);
      ld_data  = make_vec(j < K ? ba + 4*j : (j < 2*K ? bb + 4*(j - K) : 999));
      @(negedge clk);
      if (ld_ready) acc++;
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  // mode 0: pe_done in DRAIN, mode 1: drain timeout, mode 2: reset in FEED cycle 3
  task automatic run(input int ba, input int bb, input int mode);
    int done_n;
    done_n = 0;
    push_feed(ba, bb, mode == 2 ? 3 : K + N - 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("start_clears_timeout", timeout_err, 1'b0);
        check("busy_in_feed", busy, 1'b1);
      end
      if (n == 2) begin
        check("lane0_first_a_en", a_en, 4'b0001);
        check("lane0_first_b_en", b_en, 4'b0001);
        start   = 1'b1;
        pe_done = 1'b1;
      end
      if (n == 3) begin
        start   = 1'b0;
        pe_done = 1'b0;
      end
      if (mode == 2 && n == 4) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_a_en", a_en, '0);
        check("rst_b_en", b_en, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_queue_drained", q.size(), 0);
        return;
      end
      if (n == 5) begin
        check("all_lanes_en", a_en, 4'b1111);
        check("lane3_first_a", a_out[3*DW +: DW], $realtobits(real'(ba + 3)));
      end
      if (n == 8) begin
        check("lane3_last_a_en", a_en, 4'b1000);
        check("lane3_last_b_en", b_en, 4'b1000);
      end
      if (n == 9) begin
        check("drain_a_en", a_en, '0);
        check("drain_busy", busy, 1'b1);
        if (mode == 0) pe_done = 1'b1;
      end
      if (n == 10) pe_done = 1'b0;
      if (done) begin
        done_n = n;
        break;
      end
    end
    check("done_cycle", done_n, mode == 0 ? 10 : K + N - 1 + TO + 1);
    check("timeout_flag", timeout_err, mode == 1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_falls", busy, 1'b0);
    check("idle_ld_ready", ld_ready, 1'b1);
    check("timeout_sticky", timeout_err, mode == 1);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_en != '0 || b_en != '0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_feed: got a_en %b b_en %b expected no output", a_en, b_en);
        end else begin
          e = q.pop_front();
          check("feed_a_en", a_en, e.en);
          check("feed_b_en", b_en, e.en);
          check("feed_a_out", a_out, e.a);
          check("feed_b_out", b_out, e.b);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a_en", a_en, '0);
    check("reset_b_en", b_en, '0);
    check("reset_a_out", a_out, '0);
    check("reset_b_out", b_out, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_timeout", timeout_err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ld_ready", ld_ready, 1'b1);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("idle_start_busy", busy, 1'b0);
    check("idle_start_ready", ld_ready, 1'b1);
    @(posedge clk); #1;

    load(1, 17, 9, 3, acc);
    @(negedge clk);
    check("beats_accepted", acc, 8);
    check("armed_ld_ready", ld_ready, 1'b0);
    check("armed_busy", busy, 1'b1);
    @(posedge clk); #1;
    run(1, 17, 0);

    @(posedge clk); #1;
    load(33, 49, 8, -1, acc);
    check("reload_accepted", acc, 8);
    run(33, 49, 1);

    @(posedge clk); #1;
    load(65, 81, 8, -1, acc);
    @(negedge clk);
    check("timeout_held_to_start", timeout_err, 1'b1);
    @(posedge clk); #1;
    run(65, 81, 2);

    @(posedge clk); #1;
    load(97, 113, 8, -1, acc);
    check("post_reset_accepted", acc, 8);
    run(97, 113, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
